// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection controller: phase encoding, lamp codes and
// default phase durations.
package intersection_pkg;

  // Phase encoding; also driven out on the debug `phase` port.
  typedef enum logic [2:0] {
    NsGreen  = 3'd0,
    NsYellow = 3'd1,
    AllredA  = 3'd2,
    EwGreen  = 3'd3,
    EwYellow = 3'd4,
    AllredB  = 3'd5,
    PedWalk  = 3'd6
  } state_t;

  // Signal head codes, one-hot {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Default phase durations in seconds (ticks).
  localparam int unsigned DEF_GREEN_SEC  = 8;
  localparam int unsigned DEF_YELLOW_SEC = 3;
  localparam int unsigned DEF_ALLRED_SEC = 1;
  localparam int unsigned DEF_WALK_SEC   = 5;

  // A duration must fit the 4-bit display and never be zero.
  function automatic bit duration_ok(input int unsigned d);
    return (d >= 1) && (d <= 15);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase countdown: loads a duration, counts it down on each tick and pulses `expire`
// when a tick lands on the final second. The count never shows zero.
module phase_timer
  import intersection_pkg::*;
#(
  parameter int unsigned RESET_VALUE = DEF_ALLRED_SEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] remaining,
  output logic       expire
);

  logic [3:0] remaining_q, remaining_d;

  // Next count: a load wins; otherwise count down while above one.
  always_comb begin
    remaining_d = remaining_q;
    expire      = tick && (remaining_q == 4'd1);
    if (load) begin
      remaining_d = load_value;
    end else if (tick && (remaining_q > 4'd1)) begin
      remaining_d = remaining_q - 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining_q <= 4'(RESET_VALUE);
    end else begin
      remaining_q <= remaining_d;
    end
  end

  assign remaining = remaining_q;

endmodule

// File: rtl/traffic_phase_fsm.sv
// Intersection phase controller: sequences NS/EW heads, all-red clearances and an optional
// pedestrian walk phase, paced by the 1 Hz tick. All outputs are registered.
module traffic_phase_fsm
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_SEC  = DEF_GREEN_SEC,
  parameter int unsigned YELLOW_SEC = DEF_YELLOW_SEC,
  parameter int unsigned ALLRED_SEC = DEF_ALLRED_SEC,
  parameter int unsigned WALK_SEC   = DEF_WALK_SEC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [3:0] remaining,
  output logic [2:0] phase
);

  // Durations outside 1..15 cannot be displayed or counted; refuse to elaborate.
  if (!(duration_ok(GREEN_SEC) && duration_ok(YELLOW_SEC) &&
        duration_ok(ALLRED_SEC) && duration_ok(WALK_SEC))) begin : g_bad_duration
    $error("traffic_phase_fsm: phase durations must lie in 1..15");
  end

  state_t     state_q, state_d;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       ped_q, ped_d;
  logic       expire;
  logic [3:0] load_value;

  phase_timer #(
    .RESET_VALUE (ALLRED_SEC)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .load       (expire),
    .load_value (load_value),
    .remaining  (remaining),
    .expire     (expire)
  );

  // Next phase, request latch, and lamps/duration of the phase being entered.
  always_comb begin
    state_d    = state_q;
    ped_d      = ped_q;
    ns_d       = RED;
    ew_d       = RED;
    walk_d     = 1'b0;
    load_value = 4'(ALLRED_SEC);

    // A request during the walk itself is already being served.
    if (ped_req && (state_q != PedWalk)) begin
      ped_d = 1'b1;
    end

    if (expire) begin
      unique case (state_q)
        NsGreen:  state_d = NsYellow;
        NsYellow: state_d = AllredA;
        AllredA:  state_d = EwGreen;
        EwGreen:  state_d = EwYellow;
        EwYellow: state_d = AllredB;
        // Same-cycle request counts so a late press still gets this walk.
        AllredB:  state_d = (ped_q || ped_req) ? PedWalk : NsGreen;
        PedWalk:  state_d = NsGreen;
        default:  state_d = AllredB;
      endcase
      if (state_d == PedWalk) begin
        ped_d = 1'b0;
      end
    end

    unique case (state_d)
      NsGreen: begin
        ns_d       = GRN;
        load_value = 4'(GREEN_SEC);
      end
      NsYellow: begin
        ns_d       = YEL;
        load_value = 4'(YELLOW_SEC);
      end
      EwGreen: begin
        ew_d       = GRN;
        load_value = 4'(GREEN_SEC);
      end
      EwYellow: begin
        ew_d       = YEL;
        load_value = 4'(YELLOW_SEC);
      end
      PedWalk: begin
        walk_d     = 1'b1;
        load_value = 4'(WALK_SEC);
      end
      default: begin
        load_value = 4'(ALLRED_SEC);
      end
    endcase
  end

  // State, lamp and latch registers; reset parks everything in the all-red clearance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= AllredB;
      ns_q    <= RED;
      ew_q    <= RED;
      walk_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
      ped_q   <= ped_d;
    end
  end

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Self-checking bench for traffic_phase_fsm against a table-driven phase model.
module tb_traffic_phase_fsm;
  import intersection_pkg::*;

  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 1;
  localparam int W = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic       walk, ped_pending;
  logic [3:0] remaining;
  logic [14:0] dut_outputs;

  int vectors = 0;
  int miscompares = 0;

  // Model: position in the phase ring, seconds left, latched request.
  state_t seq_phase [7] = '{NsGreen, NsYellow, AllredA, EwGreen, EwYellow, AllredB, PedWalk};
  int     seq_dur   [7] = '{G, Y, A, G, Y, A, W};
  int     m_idx;
  int     m_rem;
  bit     m_pend;

  traffic_phase_fsm #(
    .GREEN_SEC  (G),
    .YELLOW_SEC (Y),
    .ALLRED_SEC (A),
    .WALK_SEC   (W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .remaining   (remaining),
    .phase       (phase)
  );

  always #5 clock = ~clock;

  assign dut_outputs = {phase, remaining, ns_light, ew_light, walk, ped_pending};

  // Lamp safety invariant on every clock.
  assert property (@(posedge clock) disable iff (reset)
    $onehot(ns_light) && $onehot(ew_light) && (ns_light == RED || ew_light == RED) &&
    (!walk || (ns_light == RED && ew_light == RED)))
  else begin
    miscompares++;
    $display("FAIL lamp_invariant ns=%b ew=%b walk=%b", ns_light, ew_light, walk);
  end

  function automatic void model_reset();
    m_idx  = 5;
    m_rem  = A;
    m_pend = 1'b0;
  endfunction

  function automatic void model_step(input logic t, input logic p);
    bit pend_next;
    pend_next = m_pend;
    if (p && seq_phase[m_idx] != PedWalk) pend_next = 1'b1;
    if (t) begin
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else begin
        if (m_idx == 5) m_idx = (m_pend || p) ? 6 : 0;
        else if (m_idx == 6) m_idx = 0;
        else m_idx = m_idx + 1;
        m_rem = seq_dur[m_idx];
        if (m_idx == 6) pend_next = 1'b0;
      end
    end
    m_pend = pend_next;
  endfunction

  function automatic logic [14:0] model_outputs();
    state_t     ph;
    logic [2:0] ns, ew;
    ph = seq_phase[m_idx];
    ns = RED;
    ew = RED;
    if (ph == NsGreen)  ns = GRN;
    if (ph == NsYellow) ns = YEL;
    if (ph == EwGreen)  ew = GRN;
    if (ph == EwYellow) ew = YEL;
    return {ph, 4'(m_rem), ns, ew, (ph == PedWalk), m_pend};
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, settle past the edge.
  task automatic drive(input logic t, input logic p);
    tick    = t;
    ped_req = p;
    @(posedge clock);
    model_step(t, p);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    vectors++;
    if (dut_outputs !== model_outputs()) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=%h", dut_outputs, model_outputs());
    end
    vectors++;
    if ({ns_light, ew_light, remaining} !== {RED, RED, 4'd1}) begin
      miscompares++;
      $display("FAIL reset_lamps got=%b want=%b", {ns_light, ew_light, remaining},
               {RED, RED, 4'd1});
    end
  endtask

  // 1 + 24 ticks from reset must land at the start of NS green again.
  task automatic test_full_cycle();
    int ticks = 0;
    int cycles = 0;
    logic t;
    while (ticks < 25 && cycles < 1000) begin
      t = ($urandom_range(0, 2) == 0);
      drive(t, 1'b0);
      cycles++;
      if (t) ticks++;
      vectors++;
      if (dut_outputs !== model_outputs()) begin
        miscompares++;
        $display("FAIL full_cycle got=%h want=%h", dut_outputs, model_outputs());
      end
    end
    vectors++;
    if ({phase, remaining} !== {NsGreen, 4'd8} || ticks != 25) begin
      miscompares++;
      $display("FAIL full_cycle_end got=%h want=%h ticks=%0d", {phase, remaining},
               {NsGreen, 4'd8}, ticks);
    end
  endtask

  task automatic test_ped_during_ew();
    int cycles = 0;
    int walk_cycles = 0;
    while (m_idx != 3 && cycles < 200) begin
      drive(1'b1, 1'b0);
      cycles++;
    end
    drive(1'b0, 1'b1);
    vectors++;
    if (ped_pending !== 1'b1 || dut_outputs !== model_outputs()) begin
      miscompares++;
      $display("FAIL ped_latch got=%h want=%h", dut_outputs, model_outputs());
    end
    cycles = 0;
    while (m_idx != 0 && cycles < 200) begin
      drive(1'b1, 1'b0);
      cycles++;
      if (walk === 1'b1) walk_cycles++;
      vectors++;
      if (dut_outputs !== model_outputs()) begin
        miscompares++;
        $display("FAIL ped_walk_seq got=%h want=%h", dut_outputs, model_outputs());
      end
    end
    vectors++;
    if (walk_cycles != W || cycles >= 200) begin
      miscompares++;
      $display("FAIL ped_walk_len got=%0d want=%0d", walk_cycles, W);
    end
  endtask

  task automatic test_ped_same_cycle();
    int cycles = 0;
    while (!(m_idx == 5 && m_rem == 1) && cycles < 200) begin
      drive(1'b1, 1'b0);
      cycles++;
    end
    drive(1'b1, 1'b1);
    vectors++;
    if ({phase, ped_pending, walk} !== {PedWalk, 1'b0, 1'b1} || cycles >= 200) begin
      miscompares++;
      $display("FAIL ped_same_cycle got=%b want=%b", {phase, ped_pending, walk},
               {PedWalk, 1'b0, 1'b1});
    end
  endtask

  task automatic test_ped_held_in_walk();
    int cycles = 0;
    repeat (W) begin
      drive(1'b1, 1'b1);
      vectors++;
      if (dut_outputs !== model_outputs()) begin
        miscompares++;
        $display("FAIL ped_held got=%h want=%h", dut_outputs, model_outputs());
      end
    end
    vectors++;
    if ({phase, ped_pending} !== {NsGreen, 1'b0}) begin
      miscompares++;
      $display("FAIL ped_held_exit got=%b want=%b", {phase, ped_pending}, {NsGreen, 1'b0});
    end
    while (m_idx != 5 && cycles < 200) begin
      drive(1'b1, 1'b0);
      cycles++;
    end
    drive(1'b1, 1'b0);
    vectors++;
    if ({phase, walk} !== {NsGreen, 1'b0} || cycles >= 200) begin
      miscompares++;
      $display("FAIL ped_held_next got=%b want=%b", {phase, walk}, {NsGreen, 1'b0});
    end
  endtask

  // Random tick/request mix, including ticks held for several cycles.
  task automatic test_random();
    logic t, p;
    for (int i = 0; i < 600; i++) begin
      t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 9) == 0);
      drive(t, p);
      vectors++;
      if (dut_outputs !== model_outputs()) begin
        miscompares++;
        $display("FAIL random[%0d] got=%h want=%h", i, dut_outputs, model_outputs());
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles = 0;
    while (!(m_idx == 0 && m_rem == 4) && cycles < 300) begin
      drive(1'b1, 1'b0);
      cycles++;
    end
    drive(1'b0, 1'b1);
    tick    = 1'b0;
    ped_req = 1'b0;
    vectors++;
    if ({phase, remaining, ped_pending} !== {NsGreen, 4'd4, 1'b1} || cycles >= 300) begin
      miscompares++;
      $display("FAIL reset_mid_setup got=%h want=%h", {phase, remaining, ped_pending},
               {NsGreen, 4'd4, 1'b1});
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (dut_outputs !== {AllredB, 4'd1, RED, RED, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", dut_outputs,
               {AllredB, 4'd1, RED, RED, 1'b0, 1'b0});
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0);
    vectors++;
    if (dut_outputs !== model_outputs()) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", dut_outputs, model_outputs());
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_during_ew();
    test_ped_same_cycle();
    test_ped_held_in_walk();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
